// File: rtl/fifo_pkg.sv
// Shared types for the FIFO burst reader: the controller state enumeration.
package fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/fifo_burst_reader.sv
// Burst reader for a showahead FIFO. It waits for a full burst's worth of
// words, or for an idle timeout, and then pops a latched number of words. The
// words leave through a one-word valid/ready output register with
// start-of-burst and end-of-burst markers.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int DWIDTH    = 8,
  parameter int AWIDTH    = 4,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic              clk_i,
  input  logic              srst_n_i,
  input  logic [DWIDTH-1:0] fifo_q_i,
  input  logic              fifo_empty_i,
  input  logic [AWIDTH-1:0] fifo_usedw_i,
  output logic              fifo_rd_req_o,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              sop_o,
  output logic              eop_o,
  output logic              busy_o
);

  // One extra bit so that a burst of 2^AWIDTH words is representable.
  localparam int LW = AWIDTH + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [LW-1:0] BURST_LEN_W = LW'(BURST_LEN);
  localparam logic [LW-1:0] ONE_W       = LW'(1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE     = TW'(1);

  state_e            state_q, state_d;
  logic [LW-1:0]     len_q,   len_d;    // latched burst length
  logic [LW-1:0]     rem_q,   rem_d;    // pops still owed in this burst
  logic [TW-1:0]     tmo_q,   tmo_d;    // idle cycles with a non-empty FIFO
  logic [DWIDTH-1:0] data_q,  data_d;
  logic              valid_q, valid_d;
  logic              sop_q,   sop_d;
  logic              eop_q,   eop_d;

  logic [LW-1:0]     usedw_ext;
  logic              full_ok;
  logic              accept;
  logic              pop;

  // A usedw of 0 with a non-empty FIFO means the FIFO is completely full.
  assign usedw_ext = {1'b0, fifo_usedw_i};
  assign full_ok   = !fifo_empty_i &&
                     ((usedw_ext >= BURST_LEN_W) || (fifo_usedw_i == '0));
  assign accept    = valid_q && ready_i;

  // Pop when the burst still owes words, the FIFO has one, and the output
  // register is free or being emptied this cycle.
  assign pop = (state_q == ST_BURST) && !fifo_empty_i && (rem_q != '0) &&
               (!valid_q || ready_i);

  // The pop request is gated by reset so no word is lost in a reset cycle.
  assign fifo_rd_req_o = srst_n_i && pop;

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign sop_o   = sop_q;
  assign eop_o   = eop_q;
  assign busy_o  = (state_q != ST_IDLE);

  // Next-state, counter and output-register logic.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would make synthesis infer a latch to hold it.
    state_d = state_q;
    len_d   = len_q;
    rem_d   = rem_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    valid_d = valid_q;
    sop_d   = sop_q;
    eop_d   = eop_q;

    // Output register: load on a pop, otherwise empty it once accepted.
    if (pop) begin
      data_d  = fifo_q_i;
      valid_d = 1'b1;
      sop_d   = (rem_q == len_q);
      eop_d   = (rem_q == ONE_W);
    end else if (accept) begin
      valid_d = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (fifo_empty_i) begin
          tmo_d = '0;
        end else if (full_ok) begin
          state_d = ST_BURST;
          len_d   = BURST_LEN_W;
          rem_d   = BURST_LEN_W;
          tmo_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          // Short burst: take whatever is there now, at least one word.
          state_d = ST_BURST;
          len_d   = usedw_ext;
          rem_d   = usedw_ext;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end

      ST_BURST: begin
        if (pop) begin
          rem_d = rem_q - ONE_W;
          if (rem_q == ONE_W) begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        // The only word left in the output register is the eop word.
        if (accept) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value regardless of statement order.
    if (!srst_n_i) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      rem_q   <= '0;
      tmo_q   <= '0;
      // NOTE: the data register is cleared as well, so downstream never sees
      // a stale word from before the reset.
      data_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader. It uses two instances: BURST_LEN=4 and
// BURST_LEN=16, both with TIMEOUT=16. Each instance reads from a queue-based
// showahead FIFO. A burst-level reference model predicts the outputs every
// cycle. Directed scenarios pin that model with hand-computed expectations,
// and a randomized run follows.
module tb_fifo_burst_reader;

  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int TO  = 16;
  localparam int BL0 = 4;
  localparam int BL1 = 16;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 srst_n;
  logic [1:0]           ready;
  logic [1:0]           empty;
  logic [1:0][DW-1:0]   head;
  logic [1:0][AW-1:0]   usedw;
  wire  [1:0]           rd_req;
  wire  [1:0]           valid;
  wire  [1:0]           sop;
  wire  [1:0]           eop;
  wire  [1:0]           busy;
  wire  [1:0][DW-1:0]   data;

  fifo_burst_reader #(.DWIDTH(DW), .AWIDTH(AW), .BURST_LEN(BL0), .TIMEOUT(TO)) dut_a (
    .clk_i(clk), .srst_n_i(srst_n), .fifo_q_i(head[0]), .fifo_empty_i(empty[0]),
    .fifo_usedw_i(usedw[0]), .fifo_rd_req_o(rd_req[0]), .data_o(data[0]),
    .valid_o(valid[0]), .ready_i(ready[0]), .sop_o(sop[0]), .eop_o(eop[0]),
    .busy_o(busy[0]));

  fifo_burst_reader #(.DWIDTH(DW), .AWIDTH(AW), .BURST_LEN(BL1), .TIMEOUT(TO)) dut_b (
    .clk_i(clk), .srst_n_i(srst_n), .fifo_q_i(head[1]), .fifo_empty_i(empty[1]),
    .fifo_usedw_i(usedw[1]), .fifo_rd_req_o(rd_req[1]), .data_o(data[1]),
    .valid_o(valid[1]), .ready_i(ready[1]), .sop_o(sop[1]), .eop_o(eop[1]),
    .busy_o(busy[1]));

  // Environment: FIFO contents and words waiting to be written next cycle.
  logic [DW-1:0] fq   [2][$];
  logic [DW-1:0] pend [2][$];
  int            usedw_add [2];
  bit            ready_drv [2];
  bit            rst_drv;

  // Logs of accepted words and pop cycles, used by the directed checks.
  logic [DW-1:0] acc_d [2][$];
  bit            acc_s [2][$];
  bit            acc_e [2][$];
  int            pop_cyc [2][$];
  bit            last_rd [2];

  // Reference model: burst bookkeeping plus the single output slot.
  bit            m_busy   [2];
  int            m_len    [2];
  int            m_popped [2];
  int            m_wait   [2];
  bit            m_valid  [2];
  bit            m_sop    [2];
  bit            m_eop    [2];
  logic [DW-1:0] m_data   [2];

  int cyc;
  int n_vec;
  int n_mis;
  bit model_on;

  function automatic int bl(input int k);
    return (k == 0) ? BL0 : BL1;
  endfunction

  task automatic check(input string name, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s dut%0d cycle %0d: got 0x%0h, expected 0x%0h",
               name, k, cyc, act, exp);
    end
  endtask

  task automatic clear_logs();
    for (int k = 0; k < 2; k++) begin
      acc_d[k].delete();
      acc_s[k].delete();
      acc_e[k].delete();
      pop_cyc[k].delete();
    end
  endtask

  // Compare one instance against the model, then advance the model by a cycle.
  task automatic model_cycle(input int k);
    bit exp_rd;
    bit accept;
    int uw;
    if (model_on) begin
      check("busy", k, busy[k], m_busy[k]);
      check("valid", k, valid[k], m_valid[k]);
      if (m_valid[k]) begin
        check("data", k, data[k], m_data[k]);
        check("sop", k, sop[k], m_sop[k]);
        check("eop", k, eop[k], m_eop[k]);
      end
    end
    if (!srst_n) begin
      if (model_on) check("rd_req_in_reset", k, rd_req[k], 1'b0);
      m_busy[k] = 0; m_len[k] = 0; m_popped[k] = 0; m_wait[k] = 0;
      m_valid[k] = 0; m_sop[k] = 0; m_eop[k] = 0; m_data[k] = '0;
    end else begin
      exp_rd = m_busy[k] && (m_popped[k] < m_len[k]) && !empty[k] &&
               (!m_valid[k] || ready[k]);
      if (model_on) check("rd_req", k, rd_req[k], exp_rd);
      accept = m_valid[k] && ready[k];
      if (m_busy[k]) begin
        if (accept && m_eop[k]) m_busy[k] = 0;
      end else if (empty[k]) begin
        m_wait[k] = 0;
      end else begin
        uw = int'(usedw[k]);
        if (uw == 0 || uw >= bl(k)) begin
          m_busy[k] = 1; m_len[k] = bl(k); m_popped[k] = 0; m_wait[k] = 0;
        end else if (m_wait[k] + 1 == TO) begin
          m_busy[k] = 1; m_len[k] = uw; m_popped[k] = 0; m_wait[k] = 0;
        end else begin
          m_wait[k]++;
        end
      end
      if (exp_rd) begin
        m_data[k]  = head[k];
        m_valid[k] = 1;
        m_sop[k]   = (m_popped[k] == 0);
        m_eop[k]   = (m_popped[k] + 1 == m_len[k]);
        m_popped[k]++;
      end else if (accept) begin
        m_valid[k] = 0; m_sop[k] = 0; m_eop[k] = 0;
      end
    end
  endtask

  // One clock cycle, entered and left just after a falling edge.
  task automatic step();
    bit pop_now [2];
    for (int k = 0; k < 2; k++) begin
      while (pend[k].size() > 0 && fq[k].size() < DEPTH)
        fq[k].push_back(pend[k].pop_front());
      pend[k].delete();
      ready[k] = ready_drv[k];
      empty[k] = (fq[k].size() == 0);
      usedw[k] = AW'((fq[k].size() + usedw_add[k]) % DEPTH);
      head[k]  = (fq[k].size() > 0) ? fq[k][0] : 8'hEE;
    end
    srst_n = rst_drv;
    #1;
    for (int k = 0; k < 2; k++) begin
      model_cycle(k);
      pop_now[k] = rd_req[k];
      last_rd[k] = rd_req[k];
      if (valid[k] && ready[k]) begin
        acc_d[k].push_back(data[k]);
        acc_s[k].push_back(sop[k]);
        acc_e[k].push_back(eop[k]);
      end
      if (rd_req[k]) pop_cyc[k].push_back(cyc);
    end
    @(posedge clk);
    model_on = 1;
    for (int k = 0; k < 2; k++)
      if (pop_now[k] && fq[k].size() > 0) void'(fq[k].pop_front());
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Accepted stream must be first, first+1, ... with sop on word 1, eop on word n.
  task automatic check_stream(input string tag, input int k, input int first, input int n);
    check({tag, "_count"}, k, acc_d[k].size(), n);
    check({tag, "_pops"}, k, pop_cyc[k].size(), n);
    for (int i = 0; i < n && i < acc_d[k].size(); i++) begin
      check({tag, "_data"}, k, acc_d[k][i], first + i);
      check({tag, "_sop"}, k, acc_s[k][i], (i == 0));
      check({tag, "_eop"}, k, acc_e[k][i], (i == n - 1));
    end
  endtask

  initial begin
    int stalls;
    int hits;
    int stall_cyc [$];
    bit found;

    n_vec = 0; n_mis = 0; cyc = 0; model_on = 0;
    rst_drv = 0;
    for (int k = 0; k < 2; k++) begin
      ready_drv[k] = 1; usedw_add[k] = 0;
    end
    @(negedge clk);

    // Reset state.
    run(3);
    for (int k = 0; k < 2; k++) begin
      check("rst_data", k, data[k], 0);
      check("rst_valid", k, valid[k], 0);
      check("rst_sop", k, sop[k], 0);
      check("rst_eop", k, eop[k], 0);
      check("rst_busy", k, busy[k], 0);
      check("rst_rd_req", k, rd_req[k], 0);
    end
    rst_drv = 1;
    run(2);

    // Four preloaded words, ready high: one full burst of consecutive pops.
    clear_logs();
    for (int i = 1; i <= 4; i++) pend[0].push_back(8'(i));
    run(12);
    check_stream("t1", 0, 1, 4);
    if (pop_cyc[0].size() == 4) check("t1_consecutive", 0, pop_cyc[0][3] - pop_cyc[0][0], 3);
    check("t1_busy_after", 0, busy[0], 0);

    // Two words, nothing added: short burst after the timeout.
    clear_logs();
    pend[0].push_back(8'h11);
    pend[0].push_back(8'h12);
    hits = cyc;
    run(30);
    check_stream("t2", 0, 8'h11, 2);
    if (pop_cyc[0].size() > 0) check("t2_first_pop_delay", 0, pop_cyc[0][0] - hits, TO);

    // Downstream stall of three cycles while word 2 is presented.
    clear_logs();
    for (int i = 0; i < 4; i++) pend[0].push_back(8'h31 + 8'(i));
    stalls = 0;
    for (int i = 0; i < 30; i++) begin
      ready_drv[0] = 1;
      if (valid[0] && data[0] == 8'h32 && stalls < 3) begin
        ready_drv[0] = 0;
        stalls++;
        stall_cyc.push_back(cyc);
      end
      step();
    end
    ready_drv[0] = 1;
    check("t3_stall_cycles", 0, stalls, 3);
    hits = 0;
    foreach (stall_cyc[i])
      foreach (pop_cyc[0][j])
        if (pop_cyc[0][j] == stall_cyc[i]) hits++;
    check("t3_pops_in_stall", 0, hits, 0);
    check_stream("t3", 0, 8'h31, 4);

    // Length 4 latched with only two words present: stall, then refill.
    clear_logs();
    pend[0].push_back(8'h41);
    pend[0].push_back(8'h42);
    usedw_add[0] = 2;
    step();
    usedw_add[0] = 0;
    run(7);
    check("t4_stall_busy", 0, busy[0], 1);
    check("t4_stall_pops", 0, pop_cyc[0].size(), 2);
    check("t4_stall_rd", 0, last_rd[0], 0);
    pend[0].push_back(8'h43);
    pend[0].push_back(8'h44);
    run(12);
    check_stream("t4", 0, 8'h41, 4);
    check("t4_busy_after", 0, busy[0], 0);

    // Completely full FIFO (usedw wraps to 0) on the 16-word instance.
    clear_logs();
    for (int i = 0; i < 16; i++) pend[1].push_back(8'h80 + 8'(i));
    run(40);
    check_stream("t5", 1, 8'h80, 16);
    if (pop_cyc[1].size() == 16) check("t5_consecutive", 1, pop_cyc[1][15] - pop_cyc[1][0], 15);

    // Reset while word 3 is presented, then a clean burst from the new head.
    clear_logs();
    for (int i = 0; i < 4; i++) pend[0].push_back(8'h61 + 8'(i));
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (valid[0] && data[0] == 8'h63) found = 1;
      else step();
    end
    check("t6_word3_seen", 0, found, 1);
    rst_drv = 0;
    step();
    check("t6_no_pop_in_reset", 0, last_rd[0], 0);
    check("t6_data", 0, data[0], 0);
    check("t6_valid", 0, valid[0], 0);
    check("t6_sop", 0, sop[0], 0);
    check("t6_eop", 0, eop[0], 0);
    check("t6_busy", 0, busy[0], 0);
    for (int i = 0; i < 3; i++) pend[0].push_back(8'h65 + 8'(i));
    step();
    rst_drv = 1;
    clear_logs();
    run(15);
    check_stream("t6", 0, 8'h64, 4);

    // Randomized traffic, backpressure and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      rst_drv = ($urandom_range(0, 599) != 0);
      for (int k = 0; k < 2; k++) begin
        ready_drv[k] = ($urandom_range(0, 3) != 0);
        case ((i / 300) % 3)
          0:       if ($urandom_range(0, 3) == 0) pend[k].push_back(8'($urandom));
          1:       if ($urandom_range(0, 1) == 0) pend[k].push_back(8'($urandom));
          default: pend[k].push_back(8'($urandom));
        endcase
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
